// File: rtl/digit_scan_mux.sv
// Four-digit multiplexed hex display scanner with frame-synchronous update.
// Define LEAD_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module digit_scan_mux #(
    parameter int PRESCALE = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Load,
    input  logic [15:0] Value,
    output logic [3:0]  Nibble,
    output logic [3:0]  DigSel,
    output logic        FrameTick
);

    localparam logic [15:0] TERM = 16'(PRESCALE - 1);

    logic [15:0] cnt;
    logic [1:0]  idx;
    logic [15:0] dispReg;
    logic [15:0] pendVal;
    logic        pendFlag;
    logic        termCnt;
    logic [3:0]  oneHot;

    assign termCnt   = (cnt == TERM);
    assign FrameTick = termCnt && (idx == 2'd3);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt      <= '0;
            idx      <= '0;
            dispReg  <= '0;
            pendVal  <= '0;
            pendFlag <= 1'b0;
        end else begin
            cnt <= termCnt ? 16'd0 : cnt + 16'd1;
            if (termCnt)
                idx <= idx + 2'd1;
            // Display only changes at the frame boundary, so a frame never tears.
            if (FrameTick) begin
                if (Load)
                    dispReg <= Value;
                else if (pendFlag)
                    dispReg <= pendVal;
                pendFlag <= 1'b0;
            end else if (Load) begin
                pendVal  <= Value;
                pendFlag <= 1'b1;
            end
        end
    end

    assign Nibble = dispReg[{idx, 2'b00} +: 4];

    always_comb begin
        oneHot = 4'b0000;
        unique case (idx)
            2'd0: oneHot = 4'b0001;
            2'd1: oneHot = 4'b0010;
            2'd2: oneHot = 4'b0100;
            2'd3: oneHot = 4'b1000;
        endcase
    end

`ifdef LEAD_ZERO_BLANK_EN
    logic [3:0] leadZero;

    // leadZero[i]: nibbles i..3 are all zero.
    always_comb begin
        leadZero    = 4'b0000;
        leadZero[3] = (dispReg[15:12] == 4'h0);
        leadZero[2] = leadZero[3] && (dispReg[11:8] == 4'h0);
        leadZero[1] = leadZero[2] && (dispReg[7:4] == 4'h0);
    end

    assign DigSel = leadZero[idx] ? 4'b0000 : oneHot;
`else
    assign DigSel = oneHot;
`endif

endmodule

// File: tb/tb_digit_scan_mux.sv
// Scoreboard bench for digit_scan_mux at PRESCALE=4.
// Stimulus pushes expected outputs per cycle; a monitor pops and compares.
module tb_digit_scan_mux;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Load = 1'b0;
    logic [15:0] Value = 16'h0;
    logic [3:0]  Nibble;
    logic [3:0]  DigSel;
    logic        FrameTick;

    int errors = 0;
    int checks = 0;
    logic [8:0] expQ[$];

    digit_scan_mux #(.PRESCALE(4)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Load(Load),
        .Value(Value),
        .Nibble(Nibble),
        .DigSel(DigSel),
        .FrameTick(FrameTick)
    );

    always #5 Clk = ~Clk;

    function automatic logic [3:0] selOf(input logic [15:0] d, input int i);
        logic [3:0] s;
        s = 4'b0001 << i;
`ifdef LEAD_ZERO_BLANK_EN
        if (i > 0 && (d >> (4 * i)) == 16'h0)
            s = 4'b0000;
`endif
        return s;
    endfunction

    // Expected outputs for cycle n (0..15) of a frame showing d.
    task automatic pushExp(input logic [15:0] d, input int n);
        int i;
        logic [3:0] nib;
        i = n / 4;
        nib = d[4*i +: 4];
        expQ.push_back({nib, selOf(d, i), (n == 15)});
    endtask

    // Runs from frame cycle 0 (already expected) through the boundary.
    task automatic frame(input logic [15:0] disp,
                         input int la, input logic [15:0] va,
                         input int lb, input logic [15:0] vb,
                         input int rstAt, input logic [15:0] nextDisp);
        for (int c = 0; c < 16; c++) begin
            Rst   = (c == rstAt);
            Load  = (c == la) || (c == lb);
            Value = (c == lb) ? vb : va;
            @(posedge Clk);
            #1;
            Rst  = 1'b0;
            Load = 1'b0;
            if (c == rstAt) begin
                pushExp(16'h0, 0);
                return;
            end
            if (c == 15)
                pushExp(nextDisp, 0);
            else
                pushExp(disp, c + 1);
        end
    endtask

    always @(negedge Clk) begin
        if (expQ.size() > 0) begin
            logic [8:0] e;
            e = expQ.pop_front();
            checks++;
            if ({Nibble, DigSel, FrameTick} !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got nib=%h sel=%b tick=%b want nib=%h sel=%b tick=%b",
                         $time, Nibble, DigSel, FrameTick, e[8:5], e[4:1], e[0]);
            end
        end
    end

    initial begin
        // Reset held two cycles
        Rst = 1'b1;
        Load = 1'b1;
        Value = 16'hFFFF;
        for (int k = 0; k < 2; k++) begin
            @(posedge Clk);
            #1;
            pushExp(16'h0, 0);
        end
        Load = 1'b0;
        Rst = 1'b0;

        // Idle frame
        frame(16'h0, -1, 16'h0, -1, 16'h0, -1, 16'h0);
        // Load mid-frame, appears next frame
        frame(16'h0, 2, 16'h1A3F, -1, 16'h0, -1, 16'h1A3F);
        // Two loads in one frame: last wins
        frame(16'h1A3F, 3, 16'h1111, 9, 16'h2222, -1, 16'h2222);
        frame(16'h2222, -1, 16'h0, -1, 16'h0, -1, 16'h2222);
        // Load on the FrameTick cycle
        frame(16'h2222, -1, 16'h0, 15, 16'hBEEF, -1, 16'hBEEF);
        // Pending load overridden by a boundary load; flag must clear
        frame(16'hBEEF, 4, 16'h1234, 15, 16'h5678, -1, 16'h5678);
        frame(16'h5678, -1, 16'h0, -1, 16'h0, -1, 16'h5678);
        // Identical value reload is harmless
        frame(16'h5678, 6, 16'h5678, -1, 16'h0, -1, 16'h5678);
        // Reset at index 2, counter 1 with a load pending
        frame(16'h5678, 1, 16'h4321, -1, 16'h0, 9, 16'h0);
        frame(16'h0, -1, 16'h0, -1, 16'h0, -1, 16'h0);
        // Reset coinciding with a boundary load
        frame(16'h0, 15, 16'hABCD, -1, 16'h0, 15, 16'h0);
        frame(16'h0, -1, 16'h0, -1, 16'h0, -1, 16'h0);
        // Leading-zero patterns
        frame(16'h0, 0, 16'h0050, -1, 16'h0, -1, 16'h0050);
        frame(16'h0050, 5, 16'h0000, -1, 16'h0, -1, 16'h0000);
        frame(16'h0000, 7, 16'h0300, -1, 16'h0, -1, 16'h0300);
        frame(16'h0300, -1, 16'h0, -1, 16'h0, -1, 16'h0300);

        for (int k = 0; k < 4 && expQ.size() > 0; k++)
            @(posedge Clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d left want 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/digit_scan_mux.md
DIGIT_SCAN_MUX -- requirements
Module: digit_scan_mux

Interface
REQ-001 Parameter PRESCALE, default 4, clock cycles each digit slot is held (legal range 2..65535).
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Rst  input  1  reset; synchronous, active-high.
REQ-004 Load  input  1  single-cycle strobe; Value is sampled on the cycle Load=1.
REQ-005 Value  input  16  four hex digits; digit0=Value[3:0] ... digit3=Value[15:12].
REQ-006 Nibble  output  4  current digit's hex code to the 7-segment decoder; Nibble[3] drives decoder In0 (MSB), Nibble[0] drives In3 (LSB).
REQ-007 DigSel  output  4  one-hot active-high digit enable; DigSel[i]=1 selects digit i.
REQ-008 FrameTick  output  1  one-cycle pulse on the last cycle of digit 3's slot.

Function
REQ-009 The prescale counter SHALL count 0..PRESCALE-1 and wrap to 0; terminal count = PRESCALE-1.
REQ-010 At terminal count, the digit index SHALL advance 0->1->2->3->0 (mod 4); otherwise it holds.
REQ-011 Nibble and DigSel SHALL be derived only from registered state (index, display register); no combinational path from Load or Value.
REQ-012 Nibble SHALL equal display register nibble [4*index+3 : 4*index]; DigSel SHALL equal 1<<index unless blanked (REQ-024).
REQ-013 FrameTick SHALL be 1 exactly when index=3 and counter=PRESCALE-1.
REQ-014 Load=1 SHALL capture Value into a pending register and set a pending flag.
REQ-015 The display register SHALL take the pending value only at a frame boundary (cycle where FrameTick=1), then clear the pending flag; no mid-frame tearing.
REQ-016 Multiple Loads within one frame: last captured Value wins.
REQ-017 Load coinciding with FrameTick: that cycle's Value SHALL go directly into the display register and the pending flag SHALL end cleared.
REQ-018 Load with no pending change and identical Value SHALL be harmless (display unchanged).
REQ-019 Latency from Load to display: at most 4*PRESCALE cycles; new value visible on the cycle after the boundary edge, with index=0.

Reset
REQ-020 Rst=1 on a rising edge SHALL set counter=0, index=0, display=0, pending=0, pending flag=0.
REQ-021 During/after reset: Nibble=4'h0, DigSel=4'b0001, FrameTick=0.
REQ-022 Rst SHALL take priority over Load and over a frame boundary in the same cycle; a pending value is discarded.
REQ-023 Rst asserted mid-slot SHALL restart scanning at digit 0 with a full PRESCALE-cycle slot after deassertion.

Configuration
REQ-024 With macro LEAD_ZERO_BLANK_EN defined: digit i (i=1..3) SHALL be blanked (DigSel=4'b0000 for its slot) when display nibbles i..3 are all zero; digit 0 is never blanked; Nibble still driven; timing and FrameTick unchanged.
REQ-025 Without LEAD_ZERO_BLANK_EN: no blanking; DigSel is always one-hot per REQ-012.

Verification (PRESCALE=4)
REQ-026 Reset, then 16 cycles idle -> DigSel 0001,0010,0100,1000 each held 4 cycles, Nibble=0, FrameTick high only on cycle 16.
REQ-027 Load Value=16'h1A3F at cycle 2 -> display unchanged until first FrameTick; next frame Nibble = F,3,A,1 with DigSel 0001..1000.
REQ-028 Loads 16'h1111 then 16'h2222 in the same frame -> next frame shows 2,2,2,2; 1111 never displayed.
REQ-029 Load 16'hBEEF on the FrameTick cycle -> following cycle index=0, Nibble=F; pending flag 0.
REQ-030 Rst asserted at index=2, counter=1 with a load pending -> DigSel=0001, Nibble=0, next frame still shows 0.
REQ-031 LEAD_ZERO_BLANK_EN defined, Value=16'h0050 -> digit slots: 0001/0,0010/5,0000,0000; Value=16'h0000 -> only digit 0 enabled.
